tbec_decoder: RTL



---
 rtl/tbec_pkg.sv | 50 +++++
 rtl/tbec_syndrome_classify.sv | 28 ++
 rtl/tbec_decoder.sv | 106 ++++++++++
 3 files changed

// File: rtl/tbec_pkg.sv
// Shared TBEC definitions: status codes, codeword field offsets and the
// check-bit generator used by both the encoder and the decoder.
package tbec_pkg;

   typedef enum logic [1:0] {
      ST_CLEAN      = 2'b00,
      ST_CORR_DATA  = 2'b01,
      ST_CORR_CHECK = 2'b10,
      ST_UNCORR     = 2'b11
   } tbec_status_e;

   localparam int DATA_LSB  = 16;
   localparam int DATA_W    = 16;
   localparam int CHECK_LSB = 0;
   localparam int CHECK_W   = 16;
   localparam int DI_LSB    = 12;
   localparam int P_LSB     = 8;
   localparam int X_LSB     = 0;

   // Codeword data field is letter-interleaved; the data word is letter-major.
   function automatic logic [15:0] code_to_data(input logic [15:0] cd);
      logic [15:0] dw;
      dw = '0;
      for (int l = 0; l < 4; l++)
         for (int p = 0; p < 4; p++)
            dw[15-4*l-p] = cd[15-4*p-l];
      return dw;
   endfunction

   // Index 0..3 of a/b/c/e is position 1..4 of letter A/B/C/D.
   function automatic logic [15:0] tbec_check(input logic [15:0] d);
      logic [3:0]  a, b, c, e;
      logic [15:0] chk;
      for (int p = 0; p < 4; p++) begin
         a[p] = d[15-p];
         b[p] = d[11-p];
         c[p] = d[7-p];
         e[p] = d[3-p];
      end
      chk = '0;
      chk[DI_LSB +: 4] = {a[0]^b[1]^c[0]^e[1], a[3]^b[2]^c[3]^e[2],
                          a[1]^b[0]^c[1]^e[0], a[2]^b[3]^c[2]^e[3]};
      chk[P_LSB +: 4]  = {a[0]^a[1]^b[0]^b[1], c[2]^c[3]^e[2]^e[3],
                          c[0]^c[1]^e[0]^e[1], a[2]^a[3]^b[2]^b[3]};
      chk[X_LSB +: 8]  = {a[0]^a[2], a[1]^a[3], b[0]^b[2], b[1]^b[3],
                          c[0]^c[2], c[1]^c[3], e[0]^e[2], e[1]^e[3]};
      return chk;
   endfunction

endpackage

// File: rtl/tbec_syndrome_classify.sv
// Maps a 16-bit TBEC syndrome to a data flip mask and a status code.
module tbec_syndrome_classify
   import tbec_pkg::*;
(
   input  logic [15:0] syn_i,
   output logic [15:0] flip_o,
   output logic [1:0]  status_o
);

   // A correctable data error has exactly the syndrome of that bit's column.
   always_comb begin
      flip_o   = '0;
      status_o = ST_UNCORR;
      if (syn_i == '0) begin
         status_o = ST_CLEAN;
      end else if ($onehot(syn_i)) begin
         status_o = ST_CORR_CHECK;
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (syn_i == tbec_check(16'(1) << i)) begin
               flip_o   = 16'(1) << i;
               status_o = ST_CORR_DATA;
            end
         end
      end
   end

endmodule

// File: rtl/tbec_decoder.sv
// Two-stage TBEC decoder with valid/ready handshake and saturating
// corrected/uncorrectable word counters.
module tbec_decoder
   import tbec_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [31:0]      in_code_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [15:0]      out_data_o,
   output logic [1:0]       out_status_o,
   input  logic             cnt_clear_i,
   output logic [CNT_W-1:0] corr_cnt_o,
   output logic [CNT_W-1:0] uncorr_cnt_o
);

   logic             adv;
   logic [15:0]      in_dw;
   logic             s1_vld_q;
   logic [15:0]      s1_data_q;
   logic [15:0]      s1_syn_q;
   logic [15:0]      flip;
   logic [1:0]       status;
   logic             out_valid_q;
   logic [15:0]      out_data_q;
   logic [1:0]       out_status_q;
   logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
   logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

   // The whole pipeline moves as one; a stalled output freezes both stages.
   assign adv        = !out_valid_q || out_ready_i;
   assign in_ready_o = adv;
   assign in_dw      = code_to_data(in_code_i[DATA_LSB +: DATA_W]);

   // Stage 1: received data word and syndrome
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q <= 1'b0;
      end else if (adv) begin
         s1_vld_q <= in_valid_i;
      end
   end

   always_ff @(posedge clk) begin
      if (adv) begin
         s1_data_q <= in_dw;
         s1_syn_q  <= tbec_check(in_dw) ^ in_code_i[CHECK_LSB +: CHECK_W];
      end
   end

   tbec_syndrome_classify u_classify (
      .syn_i    (s1_syn_q),
      .flip_o   (flip),
      .status_o (status)
   );

   // Stage 2: corrected word and status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_status_q <= ST_CLEAN;
      end else if (adv) begin
         out_valid_q  <= s1_vld_q;
         out_data_q   <= s1_data_q ^ flip;
         out_status_q <= status;
      end
   end

   always_comb begin
      corr_cnt_d   = corr_cnt_q;
      uncorr_cnt_d = uncorr_cnt_q;
      if (adv && s1_vld_q) begin
         if ((status == ST_CORR_DATA || status == ST_CORR_CHECK) && corr_cnt_q != '1)
            corr_cnt_d = corr_cnt_q + CNT_W'(1);
         if (status == ST_UNCORR && uncorr_cnt_q != '1)
            uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
      end
      if (cnt_clear_i) begin
         corr_cnt_d   = '0;
         uncorr_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
      end else begin
         corr_cnt_q   <= corr_cnt_d;
         uncorr_cnt_q <= uncorr_cnt_d;
      end
   end

   assign out_valid_o  = out_valid_q;
   assign out_data_o   = out_data_q;
   assign out_status_o = out_status_q;
   assign corr_cnt_o   = corr_cnt_q;
   assign uncorr_cnt_o = uncorr_cnt_q;

endmodule
